// File: rtl/ipsl_pcie_dma_cpld_rx_ctrl.sv
// Completion RX path: realigns 3DW-header CplD payload into packed 128b write beats and releases tags.
// Optional requester-ID filter: define IPSL_PCIE_CPLD_REQID_CHK_EN.
module ipsl_pcie_dma_cpld_rx_ctrl #(
    parameter int TAG_W = 6,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_cfg_pbus_num,
    input  logic [4:0]       i_cfg_pbus_dev_num,
    input  logic             i_axis_master_tvld,
    output logic             o_axis_master_trdy,
    input  logic [127:0]     i_axis_master_tdata,
    input  logic             i_axis_master_tlast,
    input  logic             i_wr_rdy,
    output logic             o_wr_vld,
    output logic [127:0]     o_wr_data,
    output logic [3:0]       o_wr_dw_vld,
    output logic [TAG_W-1:0] o_wr_tag,
    output logic [6:0]       o_wr_lower_addr,
    output logic             o_wr_sop,
    output logic             o_wr_eop,
    output logic             o_cpld_rcv,
    output logic [7:0]       o_cpld_tag,
    output logic             o_cpl_err,
    output logic             o_drop,
    output logic [CNT_W-1:0] o_cpld_sum
);
    typedef enum logic [1:0] {HDR, DATA, FLUSH, DROP} state_t;

    state_t             state_q, state_d;
    logic [10:0]        rem_q, rem_d;
    logic [31:0]        carry_q, carry_d;
    logic               sop_pend_q, sop_pend_d, final_q, final_d;
    logic [2:0]         status_q, status_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [6:0]         la_q, la_d;
    logic               vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic [127:0]       data_q, data_d;
    logic [3:0]         dw_q, dw_d;
    logic               rcv_q, rcv_d, err_q, err_d, drop_q, drop_d;
    logic [7:0]         ctag_q, ctag_d;
    logic [CNT_W-1:0]   sum_q, sum_d;

    logic [127:0] td;
    logic [10:0]  len_ext, rem_n;
    logic [7:0]   hdr_tag, fin_tag;
    logic         is_cpld, is_cpl, tag_ok, rid_ok, hdr_final, acc;
    logic [2:0]   n, cnt, fin_st;
    logic         emit, fin, fin_drop, fin_final, e_sop;
    logic [127:0] e_data;
    logic [3:0]   e_dw;

    assign td        = i_axis_master_tdata;
    assign len_ext   = (td[9:0] == 10'd0) ? 11'd1024 : {1'b0, td[9:0]};
    assign hdr_tag   = td[79:72];
    assign is_cpld   = td[31:24] == 8'h4A;
    assign is_cpl    = td[31:24] == 8'h0A;
    assign tag_ok    = (hdr_tag >> TAG_W) == 8'd0;
    // byte_count of 0 encodes 4096 and len of 0 encodes 1024 DW, so a 12-bit compare covers both
    assign hdr_final = td[43:32] == {td[9:0], 2'b00};

`ifdef IPSL_PCIE_CPLD_REQID_CHK_EN
    assign rid_ok = td[95:80] == {i_cfg_pbus_num, i_cfg_pbus_dev_num, 3'b000};
    logic unused_bits;
    assign unused_bits = ^{td[23:10], td[63:48], td[44], td[71]};
`else
    assign rid_ok = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{td[23:10], td[63:48], td[44], td[71], td[95:80],
                           i_cfg_pbus_num, i_cfg_pbus_dev_num};
`endif

    always_comb begin
        case (state_q)
            DROP:    o_axis_master_trdy = 1'b1;
            FLUSH:   o_axis_master_trdy = 1'b0;
            default: o_axis_master_trdy = i_wr_rdy;
        endcase
    end
    assign acc = i_axis_master_tvld & o_axis_master_trdy;

    // DATA beat: carry DW plus up to 3 new DWs go out; a 4th new DW becomes the next carry
    assign n     = (rem_q > 11'd3) ? 3'd4 : rem_q[2:0];
    assign cnt   = (n == 3'd4) ? 3'd4 : n + 3'd1;
    assign rem_n = rem_q - {8'd0, n};

    always_comb begin
        state_d = state_q;  rem_d = rem_q;  carry_d = carry_q;  sop_pend_d = sop_pend_q;
        final_d = final_q;  status_d = status_q;  tag_d = tag_q;  la_d = la_q;
        emit = 1'b0;  e_data = '0;  e_dw = '0;  e_sop = 1'b0;
        fin = 1'b0;  fin_drop = 1'b0;  fin_st = status_q;  fin_final = final_q;
        fin_tag = {{(8-TAG_W){1'b0}}, tag_q};
        rcv_d = 1'b0;  err_d = 1'b0;  drop_d = 1'b0;  ctag_d = 8'd0;  sum_d = sum_q;
        case (state_q)
            HDR: if (acc) begin
                if (is_cpld && tag_ok && rid_ok) begin
                    tag_d = hdr_tag[TAG_W-1:0];  la_d = td[70:64];
                    status_d = td[47:45];  final_d = hdr_final;
                    carry_d = td[127:96];  rem_d = len_ext - 11'd1;  sop_pend_d = 1'b1;
                    fin_st = td[47:45];  fin_final = hdr_final;  fin_tag = hdr_tag;
                    if (i_axis_master_tlast || len_ext == 11'd1) begin
                        emit = 1'b1;  e_data = {96'd0, td[127:96]};  e_dw = 4'b0001;
                        e_sop = 1'b1;  sop_pend_d = 1'b0;  fin = 1'b1;
                        fin_drop = i_axis_master_tlast ? (len_ext != 11'd1) : 1'b1;
                        state_d  = i_axis_master_tlast ? HDR : DROP;
                    end else begin
                        state_d = DATA;
                    end
                end else if (is_cpl && tag_ok && rid_ok) begin
                    err_d = 1'b1;  rcv_d = 1'b1;  ctag_d = hdr_tag;
                    if (!i_axis_master_tlast) state_d = DROP;
                end else begin
                    drop_d = 1'b1;
                    if (!i_axis_master_tlast) state_d = DROP;
                end
            end
            DATA: if (acc) begin
                emit = 1'b1;  e_data = {td[95:0], carry_q};  e_dw = 4'b1111 >> (3'd4 - cnt);
                e_sop = sop_pend_q;  sop_pend_d = 1'b0;  carry_d = td[127:96];  rem_d = rem_n;
                if (i_axis_master_tlast) begin
                    if (rem_n != 11'd0) begin
                        fin = 1'b1;  fin_drop = 1'b1;  state_d = HDR;
                    end else if (n == 3'd4) begin
                        state_d = FLUSH;
                    end else begin
                        fin = 1'b1;  state_d = HDR;
                    end
                end else if (rem_n == 11'd0) begin
                    fin = 1'b1;  fin_drop = 1'b1;  state_d = DROP;
                end
            end
            FLUSH: if (i_wr_rdy) begin
                emit = 1'b1;  e_data = {96'd0, carry_q};  e_dw = 4'b0001;
                fin = 1'b1;  state_d = HDR;
            end
            default: if (acc && i_axis_master_tlast) state_d = HDR;
        endcase
        if (fin) begin
            if (fin_drop) begin
                drop_d = 1'b1;
            end else begin
                if (fin_st != 3'b000) err_d = 1'b1;
                else                  sum_d = sum_q + CNT_W'(1);
                if (fin_st != 3'b000 || fin_final) begin
                    rcv_d = 1'b1;  ctag_d = fin_tag;
                end
            end
        end
        vld_d  = emit | (vld_q & ~i_wr_rdy);
        data_d = emit ? e_data : data_q;
        dw_d   = emit ? e_dw   : dw_q;
        sop_d  = emit ? e_sop  : sop_q;
        eop_d  = emit ? fin    : eop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR;  rem_q <= '0;  carry_q <= '0;  sop_pend_q <= 1'b0;
            final_q <= 1'b0;  status_q <= '0;  tag_q <= '0;  la_q <= '0;
            vld_q <= 1'b0;  data_q <= '0;  dw_q <= '0;  sop_q <= 1'b0;  eop_q <= 1'b0;
            rcv_q <= 1'b0;  err_q <= 1'b0;  drop_q <= 1'b0;  ctag_q <= '0;  sum_q <= '0;
        end else begin
            state_q <= state_d;  rem_q <= rem_d;  carry_q <= carry_d;  sop_pend_q <= sop_pend_d;
            final_q <= final_d;  status_q <= status_d;  tag_q <= tag_d;  la_q <= la_d;
            vld_q <= vld_d;  data_q <= data_d;  dw_q <= dw_d;  sop_q <= sop_d;  eop_q <= eop_d;
            rcv_q <= rcv_d;  err_q <= err_d;  drop_q <= drop_d;  ctag_q <= ctag_d;  sum_q <= sum_d;
        end
    end

    assign o_wr_vld        = vld_q;
    assign o_wr_data       = data_q;
    assign o_wr_dw_vld     = dw_q;
    assign o_wr_tag        = tag_q;
    assign o_wr_lower_addr = la_q;
    assign o_wr_sop        = sop_q;
    assign o_wr_eop        = eop_q;
    assign o_cpld_rcv      = rcv_q;
    assign o_cpld_tag      = ctag_q;
    assign o_cpl_err       = err_q;
    assign o_drop          = drop_q;
    assign o_cpld_sum      = sum_q;
endmodule

// File: tb/tb_ipsl_pcie_dma_cpld_rx_ctrl.sv
// Table-driven TLP stimulus with a scoreboard of expected write beats and pulses.
module tb_ipsl_pcie_dma_cpld_rx_ctrl;
    localparam int TAG_W = 6;
    localparam int CNT_W = 14;

    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] cfg_bus = 8'h02;
    logic [4:0] cfg_dev = 5'd0;
    logic tvld = 1'b0, trdy, tlast = 1'b0, wr_rdy = 1'b1;
    logic [127:0] tdata = '0;
    logic o_wr_vld, o_wr_sop, o_wr_eop, o_cpld_rcv, o_cpl_err, o_drop;
    logic [127:0] o_wr_data;
    logic [3:0] o_wr_dw_vld;
    logic [TAG_W-1:0] o_wr_tag;
    logic [6:0] o_wr_lower_addr;
    logic [7:0] o_cpld_tag;
    logic [CNT_W-1:0] o_cpld_sum;

    ipsl_pcie_dma_cpld_rx_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_cfg_pbus_num(cfg_bus), .i_cfg_pbus_dev_num(cfg_dev),
        .i_axis_master_tvld(tvld), .o_axis_master_trdy(trdy), .i_axis_master_tdata(tdata),
        .i_axis_master_tlast(tlast), .i_wr_rdy(wr_rdy), .o_wr_vld(o_wr_vld), .o_wr_data(o_wr_data),
        .o_wr_dw_vld(o_wr_dw_vld), .o_wr_tag(o_wr_tag), .o_wr_lower_addr(o_wr_lower_addr),
        .o_wr_sop(o_wr_sop), .o_wr_eop(o_wr_eop), .o_cpld_rcv(o_cpld_rcv), .o_cpld_tag(o_cpld_tag),
        .o_cpl_err(o_cpl_err), .o_drop(o_drop), .o_cpld_sum(o_cpld_sum));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ft; int len; int pay; logic [7:0] tag; logic [11:0] bc; logic [2:0] st;
        logic [15:0] rid; logic [6:0] la; bit fwd; bit rcv; bit err; bit drp; bit cnt;
    } vec_t;
    typedef struct {
        logic [127:0] data; logic [3:0] dw; logic sop; logic eop; logic [TAG_W-1:0] tag; logic [6:0] la;
    } beat_t;

    beat_t exp_q[$];
    logic [7:0] rcv_q[$];
    bit err_q[$], drop_q[$];
    int n_chk = 0, n_pass = 0, sum_exp = 0, stall_cnt = 0;
    bit rnd_en = 1'b0;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: event not expected / bound expired", nm);
    endtask

    function automatic logic [127:0] dmask(input logic [3:0] dw);
        return {{32{dw[3]}}, {32{dw[2]}}, {32{dw[1]}}, {32{dw[0]}}};
    endfunction

    // monitor: pops expectations as the DUT produces beats and pulses
    logic prev_hold = 1'b0;
    logic [127:0] held = '0;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (prev_hold) begin
                chk("hold_vld", {127'd0, o_wr_vld}, 128'd1);
                chk("hold_data", o_wr_data, held);
            end
            if (o_wr_vld && wr_rdy) begin
                if (exp_q.size() == 0) fail("extra_beat");
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", o_wr_data & dmask(e.dw), e.data & dmask(e.dw));
                    chk("beat_ctl", {109'd0, o_wr_dw_vld, o_wr_sop, o_wr_eop, o_wr_tag, o_wr_lower_addr},
                        {109'd0, e.dw, e.sop, e.eop, e.tag, e.la});
                end
            end
            prev_hold = o_wr_vld & ~wr_rdy;
            held = o_wr_data;
            if (o_cpld_rcv) begin
                if (rcv_q.size() == 0) fail("rcv_extra");
                else chk("rcv_tag", {120'd0, o_cpld_tag}, {120'd0, rcv_q.pop_front()});
            end
            if (o_cpl_err) begin
                if (err_q.size() == 0) fail("err_extra");
                else chk("err", {127'd0, o_cpl_err}, {127'd0, err_q.pop_front()});
            end
            if (o_drop) begin
                if (drop_q.size() == 0) fail("drop_extra");
                else chk("drop", {127'd0, o_drop}, {127'd0, drop_q.pop_front()});
            end
        end else prev_hold = 1'b0;
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_en) wr_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic drive_beat(input logic [127:0] d, input logic last);
        int t = 0;
        tvld = 1'b1; tdata = d; tlast = last;
        forever begin
            @(negedge clk);
            if (trdy) break;
            stall_cnt++; t++;
            if (t > 300) begin fail("trdy_timeout"); break; end
        end
        @(posedge clk); #1;
        tvld = 1'b0; tlast = 1'b0;
    endtask

    task automatic send(input vec_t v);
        logic [31:0] dq[$];
        int m, nb;
        dq.push_back({v.ft, 14'd0, 10'(v.len)});
        dq.push_back({16'h0010, v.st, 1'b0, v.bc});
        dq.push_back({v.rid, v.tag, 1'b0, v.la});
        for (int i = 0; i < v.pay; i++) dq.push_back($urandom);
        if (v.fwd) begin
            m = (v.pay < v.len) ? v.pay : v.len;
            for (int b = 0; b * 4 < m; b++) begin
                beat_t e;
                int k;
                k = (m - b * 4 > 4) ? 4 : m - b * 4;
                e.data = '0;
                for (int j = 0; j < k; j++) e.data[j*32 +: 32] = dq[3 + b*4 + j];
                e.dw = 4'b1111 >> (4 - k);
                e.sop = (b == 0); e.eop = ((b + 1) * 4 >= m);
                e.tag = v.tag[TAG_W-1:0]; e.la = v.la;
                exp_q.push_back(e);
            end
        end
        if (v.rcv) rcv_q.push_back(v.tag);
        if (v.err) err_q.push_back(1'b1);
        if (v.drp) drop_q.push_back(1'b1);
        if (v.cnt) sum_exp++;
        nb = (dq.size() + 3) / 4;
        while (dq.size() % 4 != 0) dq.push_back(32'd0);
        for (int b = 0; b < nb; b++)
            drive_beat({dq[b*4+3], dq[b*4+2], dq[b*4+1], dq[b*4]}, b == nb - 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() + rcv_q.size() + err_q.size() + drop_q.size()) != 0 && t < 1000) begin
            @(posedge clk); t++;
        end
        if (t >= 1000) fail("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] ft, input int len, input int pay, input logic [7:0] tag,
                                input logic [11:0] bc, input logic [2:0] st, input bit fwd, input bit rcv,
                                input bit err, input bit drp, input bit cnt);
        vec_t v;
        v.ft = ft; v.len = len; v.pay = pay; v.tag = tag; v.bc = bc; v.st = st; v.rid = 16'h0200;
        v.la = 7'(tag * 3 + len); v.fwd = fwd; v.rcv = rcv; v.err = err; v.drp = drp; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        //          ft     len pay tag    bc     st    fwd rcv err drp cnt
        tbl[0]  = mk(8'h4A, 1,  1,  8'd5,  12'd4,   3'b000, 1, 1, 0, 0, 1);
        tbl[1]  = mk(8'h4A, 5,  5,  8'd3,  12'd20,  3'b000, 1, 1, 0, 0, 1);
        tbl[2]  = mk(8'h4A, 32, 32, 8'd7,  12'd256, 3'b000, 1, 0, 0, 0, 1);
        tbl[3]  = mk(8'h4A, 32, 32, 8'd7,  12'd128, 3'b000, 1, 1, 0, 0, 1);
        tbl[4]  = mk(8'h0A, 0,  0,  8'd9,  12'd8,   3'b001, 0, 1, 1, 0, 0);
        tbl[5]  = mk(8'h40, 8,  8,  8'd1,  12'd0,   3'b000, 0, 0, 0, 1, 0);
        tbl[6]  = mk(8'h4A, 4,  4,  8'd11, 12'd16,  3'b100, 1, 1, 1, 0, 0);
        tbl[7]  = mk(8'h4A, 8,  4,  8'd12, 12'd32,  3'b000, 1, 0, 0, 1, 0);
        tbl[8]  = mk(8'h4A, 2,  2,  8'h45, 12'd8,   3'b000, 0, 0, 0, 1, 0);
        tbl[9]  = mk(8'h4A, 1,  5,  8'd13, 12'd4,   3'b000, 1, 0, 0, 1, 0);
        tbl[10] = mk(8'h4A, 7,  7,  8'd0,  12'd28,  3'b000, 1, 1, 0, 0, 1);
        tbl[11] = mk(8'h4A, 4,  4,  8'd63, 12'd16,  3'b000, 1, 1, 0, 0, 1);
`ifdef IPSL_PCIE_CPLD_REQID_CHK_EN
        tbl[12] = mk(8'h4A, 2,  2,  8'd14, 12'd8,   3'b000, 0, 0, 0, 1, 0);
`else
        tbl[12] = mk(8'h4A, 2,  2,  8'd14, 12'd8,   3'b000, 1, 1, 0, 0, 1);
`endif
        tbl[12].rid = 16'h0100;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", {127'd0, o_wr_vld}, 128'd0);
        chk("rst_pulses", {125'd0, o_cpld_rcv, o_cpl_err, o_drop}, 128'd0);
        chk("rst_sum", {114'd0, o_cpld_sum}, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) send(tbl[i]);
        drain();
        chk("sum_table", {114'd0, o_cpld_sum}, 128'(sum_exp));

        // FLUSH holds off the next header for exactly one cycle
        stall_cnt = 0;
        send(tbl[1]); send(tbl[0]);
        drain();
        chk("flush_stall", 128'(stall_cnt), 128'd1);

        // downstream back-pressure mid-TLP
        fork
            send(mk(8'h4A, 16, 16, 8'd20, 12'd64, 3'b000, 1, 1, 0, 0, 1));
            begin repeat (4) @(posedge clk); #1 wr_rdy = 1'b0; repeat (3) @(posedge clk); #1 wr_rdy = 1'b1; end
        join
        drain();

        // reset in the middle of a TLP: next beat is parsed as a header
        drive_beat({32'h0, 16'h0200, 8'd4, 1'b0, 7'd0, 32'h0010_0020, 8'h4A, 14'd0, 10'd8}, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; sum_exp = 0;
        chk("rst_mid_sum", {114'd0, o_cpld_sum}, 128'd0);
        send(mk(8'h4A, 1, 1, 8'd2, 12'd4, 3'b000, 1, 1, 0, 0, 1));
        drain();

        // random lengths under random back-pressure
        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int l;
            l = $urandom_range(1, 40);
            send(mk(8'h4A, l, l, 8'($urandom_range(0, 63)), 12'(l * 4), 3'b000, 1, 1, 0, 0, 1));
        end
        @(posedge clk); #1 rnd_en = 1'b0;
        @(posedge clk); #2 wr_rdy = 1'b1;
        drain();

        chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
        chk("sum_final", {114'd0, o_cpld_sum}, 128'(sum_exp));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
